tmds_symbol_decoder: RTL and testbench

//  Receive-side counterpart of the TMDS transmit path: one instance per TMDS channel, fed by a 10:1 deserializer
//  in the clk_pixel domain. Recovers 10-bit word alignment by hunting for control-token runs in blanking, then

---
 rtl/tmds_pkg.sv | 21 ++
 rtl/tmds_word_aligner.sv | 80 ++++++++
 rtl/tmds_symbol_decoder.sv | 89 ++++++++
 tb/tb_tmds_symbol_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, TERC4 code table and aligner state shared by the receive decoder.
package tmds_pkg;

    typedef enum logic {SEARCH, LOCKED} aligner_state_e;

    // Index is the {c1,c0} value carried by the token.
    localparam logic [9:0] CTRL_TOKENS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    localparam logic [9:0] TERC4_CODES [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    function automatic logic is_ctrl_token(input logic [9:0] q);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) hit = hit | (q == CTRL_TOKENS[i]);
        return hit;
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// tmds_word_aligner: finds the 10-bit symbol boundary by hunting for control-token runs,
// slipping one bit per search window and dropping lock when runs stop appearing.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 1024,
    parameter int LOSS_TIMEOUT  = 2048
)(
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] i_symbol,
    input  logic       i_valid,
    output logic [9:0] o_aligned,
    output logic       o_locked,
    output logic [3:0] o_bit_offset
);
    localparam int RW = $clog2(LOCK_RUN + 1);
    localparam int SW = $clog2(SEARCH_WINDOW);
    localparam int LW = $clog2(LOSS_TIMEOUT);

    aligner_state_e r_state, w_state;
    logic [19:0]    r_window;
    logic [9:0]     w_word;
    logic [3:0]     r_offset, w_offset;
    logic [RW-1:0]  r_run, w_run;
    logic [SW-1:0]  r_search, w_search;
    logic [LW-1:0]  r_loss, w_loss;
    logic           w_hit;

    assign w_word       = 10'(r_window >> r_offset);
    assign o_locked     = r_state == LOCKED;
    assign o_bit_offset = r_offset;

    always_comb begin
        w_run    = is_ctrl_token(w_word) ? ((r_run == RW'(LOCK_RUN)) ? r_run : r_run + 1'b1) : '0;
        w_hit    = w_run == RW'(LOCK_RUN);
        w_state  = r_state;
        w_offset = r_offset;
        w_search = r_search;
        w_loss   = r_loss;
        if (r_state == SEARCH) begin
            if (w_hit) w_state = LOCKED;
            else if (r_search == SW'(SEARCH_WINDOW - 1)) begin
                w_offset = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                w_search = '0;
                w_run    = '0;
            end else w_search = r_search + 1'b1;
        end else begin
            // A completing run refreshes lock even on the timeout cycle.
            if (w_hit) w_loss = '0;
            else if (r_loss == LW'(LOSS_TIMEOUT - 1)) begin
                w_state  = SEARCH;
                w_loss   = '0;
                w_search = '0;
            end else w_loss = r_loss + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= SEARCH;
            r_window  <= '0;
            o_aligned <= '0;
            r_offset  <= '0;
            r_run     <= '0;
            r_search  <= '0;
            r_loss    <= '0;
        end else if (i_valid) begin
            r_state   <= w_state;
            r_window  <= {i_symbol, r_window[19:10]};
            o_aligned <= w_word;
            r_offset  <= w_offset;
            r_run     <= w_run;
            r_search  <= w_search;
            r_loss    <= w_loss;
        end
    end

endmodule

// File: rtl/tmds_symbol_decoder.sv
// tmds_symbol_decoder: one TMDS channel receiver; word alignment plus video/control/TERC4 decode.
module tmds_symbol_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN      = 8,
    parameter int SEARCH_WINDOW = 1024,
    parameter int LOSS_TIMEOUT  = 2048
)(
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] symbol_in,
    input  logic       symbol_valid,
    output logic       out_valid,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic [3:0] terc4,
    output logic       terc4_valid
);
    logic [9:0] w_aligned;
    logic [7:0] w_vid, w_data;
    logic       w_is_ctrl, w_t4_hit;
    logic [1:0] w_ctrl;
    logic [3:0] w_t4;
    logic       r_v1, r_v2;

    tmds_word_aligner #(
        .LOCK_RUN      (LOCK_RUN),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .LOSS_TIMEOUT  (LOSS_TIMEOUT)
    ) u_aligner (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .i_symbol     (symbol_in),
        .i_valid      (symbol_valid),
        .o_aligned    (w_aligned),
        .o_locked     (locked),
        .o_bit_offset (bit_offset)
    );

    always_comb begin
        w_vid     = w_aligned[9] ? ~w_aligned[7:0] : w_aligned[7:0];
        w_data    = '0;
        w_data[0] = w_vid[0];
        for (int i = 1; i < 8; i++)
            w_data[i] = w_aligned[8] ? w_vid[i] ^ w_vid[i-1] : ~(w_vid[i] ^ w_vid[i-1]);
        w_is_ctrl = 1'b0;
        w_ctrl    = ctrl;
        for (int i = 0; i < 4; i++)
            if (w_aligned == CTRL_TOKENS[i]) begin
                w_is_ctrl = 1'b1;
                w_ctrl    = 2'(i);
            end
        w_t4_hit = 1'b0;
        w_t4     = '0;
        for (int i = 0; i < 16; i++)
            if (w_aligned == TERC4_CODES[i]) begin
                w_t4_hit = 1'b1;
                w_t4     = 4'(i);
            end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            out_valid   <= 1'b0;
            de          <= 1'b0;
            data        <= '0;
            ctrl        <= '0;
            terc4       <= '0;
            terc4_valid <= 1'b0;
        end else begin
            out_valid <= symbol_valid & r_v2;
            if (symbol_valid) begin
                r_v1        <= 1'b1;
                r_v2        <= r_v1;
                de          <= ~w_is_ctrl;
                data        <= w_is_ctrl ? '0 : w_data;
                ctrl        <= w_ctrl;
                terc4       <= w_t4;
                terc4_valid <= w_t4_hit;
            end
        end
    end

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// tb_tmds_symbol_decoder: directed random-data scenarios checked every cycle against a bit-stream model
// of the receiver, plus end-to-end byte checks through a TMDS encoder.
module tb_tmds_symbol_decoder;

    logic       clk_pixel = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] symbol_in = '0;
    logic       symbol_valid = 1'b0;
    logic       out_valid, locked, de, terc4_valid;
    logic [3:0] bit_offset, terc4;
    logic [7:0] data;
    logic [1:0] ctrl;

    always #5 clk_pixel = ~clk_pixel;

    tmds_symbol_decoder dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .symbol_in    (symbol_in),
        .symbol_valid (symbol_valid),
        .out_valid    (out_valid),
        .locked       (locked),
        .bit_offset   (bit_offset),
        .de           (de),
        .data         (data),
        .ctrl         (ctrl),
        .terc4        (terc4),
        .terc4_valid  (terc4_valid)
    );

    localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    localparam logic [9:0] T4 [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    int vectors = 0, miscompares = 0;

    // Model: last 20 received bits (oldest first at bit 0), word awaiting decode, and aligner bookkeeping.
    logic [19:0] m_bits;
    logic [9:0]  m_pend;
    int          m_off, m_run, m_scnt, m_lcnt, m_vcnt;
    bit          m_locked;
    logic        e_ov, e_de, e_t4v;
    logic [7:0]  e_data;
    logic [1:0]  e_ctrl;
    logic [3:0]  e_t4;

    logic [7:0] tx_b [0:10299];
    bit         tx_c [0:10299];

    function automatic int find_tok(input logic [9:0] q);
        for (int i = 0; i < 4; i++) if (q == TOK[i]) return i;
        return -1;
    endfunction

    function automatic int find_t4(input logic [9:0] q);
        for (int i = 0; i < 16; i++) if (q == T4[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] vdec(input logic [9:0] q);
        logic [7:0] v, d;
        v = q[9] ? ~q[7:0] : q[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) d[i] = v[i] ^ v[i-1] ^ ~q[8];
        return d;
    endfunction

    function automatic logic [9:0] venc(input logic [7:0] d, input bit inv);
        logic [7:0] qm;
        bit xn;
        xn = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        return {inv, ~xn, inv ? ~qm : qm};
    endfunction

    function automatic logic [9:0] rnd_video();
        logic [9:0] w;
        do w = venc(8'($urandom), bit'($urandom_range(0, 1))); while (find_tok(w) >= 0);
        return w;
    endfunction

    task automatic model_reset();
        m_bits = '0; m_pend = '0;
        m_off = 0; m_run = 0; m_scnt = 0; m_lcnt = 0; m_vcnt = 0; m_locked = 0;
        e_ov = 0; e_de = 0; e_data = '0; e_ctrl = '0; e_t4 = '0; e_t4v = 0;
    endtask

    task automatic model_step(input logic [9:0] sym);
        logic [9:0] w;
        int k, t;
        w = 10'(m_bits >> m_off);
        k = find_tok(m_pend);
        t = find_t4(m_pend);
        e_de   = k < 0;
        e_data = (k < 0) ? vdec(m_pend) : 8'h00;
        if (k >= 0) e_ctrl = 2'(k);
        e_t4v  = t >= 0;
        e_t4   = (t >= 0) ? 4'(t) : 4'h0;
        m_pend = w;
        m_run  = (find_tok(w) >= 0) ? ((m_run < 8) ? m_run + 1 : 8) : 0;
        if (!m_locked) begin
            if (m_run == 8) begin m_locked = 1; m_lcnt = 0; end
            else if (m_scnt == 1023) begin m_off = (m_off + 1) % 10; m_scnt = 0; m_run = 0; end
            else m_scnt++;
        end else begin
            if (m_run == 8) m_lcnt = 0;
            else if (m_lcnt == 2047) begin m_locked = 0; m_scnt = 0; m_lcnt = 0; end
            else m_lcnt++;
        end
        m_bits = {sym, m_bits[19:10]};
        m_vcnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("bit_offset", 32'(bit_offset), 32'(m_off));
        chk("de", 32'(de), 32'(e_de));
        chk("data", 32'(data), 32'(e_data));
        chk("ctrl", 32'(ctrl), 32'(e_ctrl));
        chk("terc4", 32'(terc4), 32'(e_t4));
        chk("terc4_valid", 32'(terc4_valid), 32'(e_t4v));
    endtask

    task automatic step(input logic [9:0] sym, input bit vld);
        symbol_in = sym;
        symbol_valid = vld;
        @(posedge clk_pixel);
        if (vld) model_step(sym);
        e_ov = vld && m_vcnt >= 3;
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        for (int i = 0; i < 3; i++) begin
            symbol_in = 10'($urandom);
            symbol_valid = 1'b1;
            @(posedge clk_pixel);
            #1 check_all();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        logic [9:0] tx_w, prev_tx;
        int prev_off;
        bit saw_wrap;
        model_reset();
        // Reset held with random input.
        for (int i = 0; i < 5; i++) begin
            symbol_in = 10'($urandom);
            symbol_valid = bit'($urandom_range(0, 1));
            @(posedge clk_pixel);
            #1 check_all();
        end
        reset_n = 1'b1;

        // Lock at offset 0, then a known video byte.
        for (int i = 0; i < 12; i++) step(10'h354, 1'b1);
        chk("lock0_locked", 32'(locked), 32'd1);
        chk("lock0_de", 32'(de), 32'd0);
        chk("lock0_ctrl", 32'(ctrl), 32'd0);
        step(venc(8'hA5, 1'b0), 1'b1);
        for (int i = 0; i < 3; i++) step(rnd_video(), 1'b1);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_de", 32'(de), 32'd1);

        // TERC4 table walk.
        for (int i = 0; i < 8; i++) step(10'h354, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step((i < 16) ? T4[i] : 10'h354, 1'b1);
            if (i >= 3) begin
                chk("terc4_seq", 32'(terc4), (i - 3 < 16) ? 32'(i - 3) : 32'd0);
                chk("terc4_seq_valid", 32'(terc4_valid), 32'(i - 3 < 16));
            end
        end

        // Loss of lock with a stall in the middle, then relock.
        for (int i = 0; i < 10; i++) step(10'h154, 1'b1);
        for (int i = 0; i < 2060; i++) begin
            if (i == 1000)
                for (int j = 0; j < 100; j++) begin
                    step(10'($urandom), 1'b0);
                    chk("stall_out_valid", 32'(out_valid), 32'd0);
                    chk("stall_locked", 32'(locked), 32'd1);
                end
            step(rnd_video(), 1'b1);
        end
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_offset", 32'(bit_offset), 32'd0);
        for (int i = 0; i < 10; i++) step(10'h2AB, 1'b1);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_ctrl", 32'(ctrl), 32'd3);

        // Mid-operation reset, then broken runs that must never lock.
        pulse_reset();
        for (int t = 0; t < 8242; t++) begin
            step((t % 8 == 7) ? rnd_video() : 10'h154, 1'b1);
            if (t == 1022) chk("slip_before", 32'(bit_offset), 32'd0);
            if (t == 1023) chk("slip_after", 32'(bit_offset), 32'd1);
        end
        chk("broken_locked", 32'(locked), 32'd0);
        chk("broken_offset", 32'(bit_offset), 32'd8);

        // NTSC lines shifted by 7 bits: blank 0x0AB tokens, then video.
        prev_tx = '0;
        prev_off = int'(bit_offset);
        saw_wrap = 0;
        for (int t = 0; t < 10296; t++) begin
            tx_c[t] = (t % 858) < 138;
            tx_b[t] = 8'($urandom);
            tx_w = tx_c[t] ? 10'h0AB : venc(tx_b[t], bit'($urandom_range(0, 1)));
            step({tx_w[2:0], prev_tx[9:3]}, 1'b1);
            prev_tx = tx_w;
            if (prev_off == 9 && bit_offset == 4'd0) saw_wrap = 1;
            prev_off = int'(bit_offset);
            if (locked && t >= 3) begin
                chk("ntsc_de", 32'(de), 32'(!tx_c[t-3]));
                if (tx_c[t-3]) chk("ntsc_ctrl", 32'(ctrl), 32'd1);
                else chk("ntsc_data", 32'(data), 32'(tx_b[t-3]));
            end
        end
        chk("ntsc_locked", 32'(locked), 32'd1);
        chk("ntsc_offset", 32'(bit_offset), 32'd7);
        chk("ntsc_wrap", 32'(saw_wrap), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
